// File: rtl/delay_line_uart_pkg.sv
// Shared types, command bytes and bit-timing helpers for the delay-line UART dump engine.
// Pure declarations: no latency, no flow control.
package delay_line_uart_pkg;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

   localparam logic [7:0] CMD_SNAP = 8'h53;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_STOP = 8'h58;

   function automatic int calc_top(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int calc_half(input int clk_hz, input int baud);
      return calc_top(clk_hz, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with two-flop synchroniser; rx_valid pulses one cycle per good frame.
// Latency: 2 + HALF + 9*TOP cycles from start edge; no backpressure, framing errors are dropped.
module uart_rx_byte
   import delay_line_uart_pkg::*;
#(
   parameter int P_CLK_HZ = 12000000,
   parameter int P_BAUD   = 115200
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       uart_rx,
   output logic       rx_valid,
   output logic [7:0] rx_data
);

   localparam int TOP  = calc_top(P_CLK_HZ, P_BAUD);
   localparam int HALF = calc_half(P_CLK_HZ, P_BAUD);
   localparam int TW   = $clog2(TOP);
   localparam logic [TW-1:0] T_LAST = TW'(TOP - 1);
   localparam logic [TW-1:0] T_MID  = TW'(HALF - 1);

   logic          rx_meta, rx_sync;
   rx_state_t     state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          valid_nxt;
   logic [7:0]    data_nxt;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         state    <= R_IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_meta  <= uart_rx;
         rx_sync  <= rx_meta;
         state    <= state_nxt;
         timer    <= timer_nxt;
         bit_idx  <= bit_nxt;
         shreg    <= shreg_nxt;
         rx_valid <= valid_nxt;
         rx_data  <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer + TW'(1);
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      valid_nxt = 1'b0;
      data_nxt  = rx_data;
      case (state)
         R_IDLE: begin
            timer_nxt = '0;
            if (!rx_sync) state_nxt = R_START;
         end
         R_START: begin
            // Re-check the line near mid start bit so short glitches never open a frame
            if (timer == T_MID) begin
               timer_nxt = '0;
               bit_nxt   = '0;
               state_nxt = rx_sync ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (timer == T_LAST) begin
               timer_nxt = '0;
               shreg_nxt = {rx_sync, shreg[7:1]};
               if (bit_idx == 3'd7) state_nxt = R_STOP;
               else                 bit_nxt   = bit_idx + 3'd1;
            end
         end
         R_STOP: begin
            if (timer == T_LAST) begin
               timer_nxt = '0;
               state_nxt = R_IDLE;
               if (rx_sync) begin
                  valid_nxt = 1'b1;
                  data_nxt  = shreg;
               end
            end
         end
         default: state_nxt = R_IDLE;
      endcase
   end

endmodule

// File: rtl/delay_line_uart_dump.sv
// UART command decoder that snapshots the delay-line word and streams it LSB byte first as 8N1 frames.
// Latency: first start bit one cycle after command rx_valid; no backpressure, 'S'/'C' ignored while busy.
module delay_line_uart_dump
   import delay_line_uart_pkg::*;
#(
   parameter int P_LENGTH = 32,
   parameter int P_CLK_HZ = 12000000,
   parameter int P_BAUD   = 115200
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   input  logic [P_LENGTH-1:0] i_data,
   input  logic                i_uart_rx,
   output logic                o_uart_tx,
   output logic                o_busy,
   output logic                o_cont
);

   localparam int TOP    = calc_top(P_CLK_HZ, P_BAUD);
   localparam int TW     = $clog2(TOP);
   localparam int NBYTES = P_LENGTH / 8;
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TOP - 1);
   localparam logic [BW-1:0] B_LAST = BW'(NBYTES - 1);

   logic       rx_valid;
   logic [7:0] rx_data;

   uart_rx_byte #(
      .P_CLK_HZ (P_CLK_HZ),
      .P_BAUD   (P_BAUD)
   ) u_rx (
      .i_clk    (i_clk),
      .i_nrst   (i_nrst),
      .uart_rx  (i_uart_rx),
      .rx_valid (rx_valid),
      .rx_data  (rx_data)
   );

   logic cmd_snap, cmd_cont, cmd_stop;
   assign cmd_snap = rx_valid && (rx_data == CMD_SNAP);
   assign cmd_cont = rx_valid && (rx_data == CMD_CONT);
   assign cmd_stop = rx_valid && (rx_data == CMD_STOP);

   tx_state_t           tx_state, state_nxt;
   logic [TW-1:0]       timer, timer_nxt;
   logic [2:0]          bit_idx, bit_nxt;
   logic [BW-1:0]       byte_idx, byte_nxt;
   logic [P_LENGTH-1:0] snap, snap_nxt;
   logic [P_LENGTH-1:0] tx_word;
   logic [7:0]          tx_byte;
   logic                cont, cont_nxt;
   logic                tx_q, tx_nxt;
   logic                load;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         tx_state <= T_IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         snap     <= '0;
         cont     <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_state <= state_nxt;
         timer    <= timer_nxt;
         bit_idx  <= bit_nxt;
         byte_idx <= byte_nxt;
         snap     <= snap_nxt;
         cont     <= cont_nxt;
         tx_q     <= tx_nxt;
      end
   end

   always_comb begin
      cont_nxt = cont;
      if (cmd_cont)      cont_nxt = 1'b1;
      else if (cmd_stop) cont_nxt = 1'b0;

      state_nxt = tx_state;
      timer_nxt = timer + TW'(1);
      bit_nxt   = bit_idx;
      byte_nxt  = byte_idx;
      load      = 1'b0;
      case (tx_state)
         T_IDLE: begin
            timer_nxt = '0;
            if (cmd_snap || cmd_cont) begin
               state_nxt = T_START;
               bit_nxt   = '0;
               byte_nxt  = '0;
               load      = 1'b1;
            end
         end
         T_START: begin
            if (timer == T_LAST) begin
               timer_nxt = '0;
               bit_nxt   = '0;
               state_nxt = T_DATA;
            end
         end
         T_DATA: begin
            if (timer == T_LAST) begin
               timer_nxt = '0;
               if (bit_idx == 3'd7) state_nxt = T_STOP;
               else                 bit_nxt   = bit_idx + 3'd1;
            end
         end
         T_STOP: begin
            if (timer == T_LAST) begin
               timer_nxt = '0;
               if (byte_idx == B_LAST) begin
                  // A 'C' landing on this edge folds into the restart instead of starting twice
                  byte_nxt = '0;
                  if (cont_nxt) begin
                     state_nxt = T_START;
                     load      = 1'b1;
                  end else begin
                     state_nxt = T_IDLE;
                  end
               end else begin
                  byte_nxt  = byte_idx + BW'(1);
                  state_nxt = T_START;
               end
            end
         end
         default: state_nxt = T_IDLE;
      endcase

      snap_nxt = load ? i_data : snap;
      tx_word  = snap_nxt >> {byte_nxt, 3'b000};
      tx_byte  = tx_word[7:0];
      // Line level is registered from next-state so the pin is glitch-free and aligned to state
      case (state_nxt)
         T_START: tx_nxt = 1'b0;
         T_DATA:  tx_nxt = tx_byte[bit_nxt];
         default: tx_nxt = 1'b1;
      endcase
   end

   assign o_uart_tx = tx_q;
   assign o_busy    = (tx_state != T_IDLE);
   assign o_cont    = cont;

endmodule

// File: tb/tb_delay_line_uart_dump.sv
// Scoreboard bench: expected bytes queued when commands are sent, popped as TX frames are decoded.
module tb_delay_line_uart_dump;

   logic        i_clk = 1'b0;
   logic        i_nrst;
   logic [31:0] i_data;
   logic        i_uart_rx;
   logic        o_uart_tx, o_busy, o_cont;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] sb_q[$];
   int         fs_q[$];
   int         busy_q[$];
   int         last_rxv  = -1;
   int         rxv53     = 0;
   int         cont_fall = -1;

   delay_line_uart_dump #(
      .P_LENGTH (32),
      .P_CLK_HZ (16),
      .P_BAUD   (1)
   ) dut (
      .i_clk     (i_clk),
      .i_nrst    (i_nrst),
      .i_data    (i_data),
      .i_uart_rx (i_uart_rx),
      .o_uart_tx (o_uart_tx),
      .o_busy    (o_busy),
      .o_cont    (o_cont)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) sb_q.push_back(w[8*k +: 8]);
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop);
      i_uart_rx = 1'b0;
      repeat (16) @(negedge i_clk);
      for (int i = 0; i < 8; i++) begin
         i_uart_rx = b[i];
         repeat (16) @(negedge i_clk);
      end
      i_uart_rx = stop;
      repeat (16) @(negedge i_clk);
      i_uart_rx = 1'b1;
   endtask

   task automatic wait_dump(input int budget, output int dur);
      int n;
      n = 0;
      while (busy_q.size() == 0 && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      if (busy_q.size() == 0) begin
         chk("dump_timeout", n, budget + 1);
         dur = 0;
      end else begin
         dur = busy_q.pop_front();
      end
   endtask

   // Frame decoder, busy/cont edge tracker and rx_valid observer
   initial begin : mon
      bit         act;
      int         cnt;
      int         bstart;
      logic [7:0] sh;
      logic       pb, pc;
      act = 0; cnt = 0; bstart = 0; sh = '0; pb = 0; pc = 0;
      forever begin
         @(negedge i_clk);
         if (dut.rx_valid) begin
            last_rxv = cyc;
            if (dut.rx_data == 8'h53) rxv53++;
         end
         if (o_busy && !pb) bstart = cyc;
         if (!o_busy && pb) busy_q.push_back(cyc - bstart);
         if (!o_cont && pc) cont_fall = cyc;
         pb = o_busy;
         pc = o_cont;
         if (!i_nrst) begin
            act = 0;
         end else if (!act) begin
            if (!o_uart_tx) begin
               act = 1;
               cnt = 0;
               fs_q.push_back(cyc);
            end
         end else begin
            cnt++;
            if (cnt == 8) chk("start_bit", o_uart_tx, 1'b0);
            if (cnt >= 24 && cnt <= 136 && ((cnt - 8) % 16) == 0) sh = {o_uart_tx, sh[7:1]};
            if (cnt == 152) begin
               chk("stop_bit", o_uart_tx, 1'b1);
               chk("frame_expected", sb_q.size() > 0, 1'b1);
               if (sb_q.size() > 0) chk("frame_byte", sh, sb_q.pop_front());
            end
            if (cnt == 159) act = 0;
         end
      end
   end

   initial begin
      int dur, viol, base, xv, target, n;
      i_nrst    = 1'b0;
      i_uart_rx = 1'b1;
      i_data    = '0;
      repeat (3) @(negedge i_clk);
      chk("rst_tx", o_uart_tx, 1'b1);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_cont", o_cont, 1'b0);
      i_nrst = 1'b1;

      viol = 0;
      repeat (500) begin
         @(negedge i_clk);
         if (o_uart_tx !== 1'b1 || o_busy !== 1'b0 || o_cont !== 1'b0) viol++;
      end
      chk("idle_500", viol, 0);

      // Single dump; input word changes mid-dump
      fs_q.delete();
      i_data = 32'hA5C3_1E7F;
      push_word(i_data);
      uart_send(8'h53, 1'b1);
      repeat (200) @(negedge i_clk);
      i_data = 32'h1234_5678;
      wait_dump(1200, dur);
      chk("single_dur", dur, 640);
      chk("single_frames", fs_q.size(), 4);
      if (fs_q.size() == 4) begin
         chk("cmd_latency", fs_q[0] - last_rxv, 1);
         chk("single_span", fs_q[3] - fs_q[0], 480);
      end
      chk("busy_after", o_busy, 1'b0);

      // Continuous mode, stopped during the second dump
      fs_q.delete();
      i_data = 32'hDEAD_BEEF;
      push_word(i_data);
      uart_send(8'h43, 1'b1);
      chk("cont_set", o_cont, 1'b1);
      i_data = 32'h0F1E_2D3C;
      push_word(i_data);
      repeat (640) @(negedge i_clk);
      uart_send(8'h58, 1'b1);
      xv = last_rxv;
      wait_dump(2500, dur);
      chk("cont_dur", dur, 1280);
      chk("cont_fall_lat", cont_fall - xv, 1);
      chk("cont_clear", o_cont, 1'b0);
      repeat (400) @(negedge i_clk);
      chk("no_third_dump", busy_q.size(), 0);
      chk("cont_frames", fs_q.size(), 8);
      if (fs_q.size() >= 5) chk("cont_gapless", fs_q[4] - fs_q[3], 160);

      // Glitch and framing error are rejected; a good 'S' afterwards works
      fs_q.delete();
      base = rxv53;
      i_uart_rx = 1'b0;
      repeat (4) @(negedge i_clk);
      i_uart_rx = 1'b1;
      repeat (40) @(negedge i_clk);
      uart_send(8'h53, 1'b0);
      repeat (60) @(negedge i_clk);
      chk("reject_rxv", rxv53 - base, 0);
      chk("reject_frames", fs_q.size(), 0);
      chk("reject_busy", o_busy, 1'b0);
      i_data = 32'h8C4B_2A19;
      push_word(i_data);
      uart_send(8'h53, 1'b1);
      wait_dump(1200, dur);
      chk("after_err_dur", dur, 640);

      // Asynchronous reset in the third data bit of byte 1
      fs_q.delete();
      i_data = 32'h6ED9_FB37;
      push_word(i_data);
      uart_send(8'h53, 1'b1);
      n = 0;
      while (fs_q.size() < 2 && n < 600) begin
         @(negedge i_clk);
         n++;
      end
      chk("byte1_seen", fs_q.size() >= 2, 1'b1);
      if (fs_q.size() >= 2) begin
         target = fs_q[1] + 56;
         while (cyc < target) @(negedge i_clk);
         #2;
         chk("pre_rst_bit", o_uart_tx, 1'b0);
         i_nrst = 1'b0;
         #1;
         chk("arst_tx", o_uart_tx, 1'b1);
         chk("arst_busy", o_busy, 1'b0);
         chk("arst_cont", o_cont, 1'b0);
      end
      repeat (4) @(negedge i_clk);
      i_nrst = 1'b1;
      sb_q.delete();
      busy_q.delete();
      repeat (20) @(negedge i_clk);
      i_data = 32'h3C96_E10B;
      push_word(i_data);
      uart_send(8'h53, 1'b1);
      wait_dump(1200, dur);
      chk("post_rst_dur", dur, 640);
      repeat (20) @(negedge i_clk);
      chk("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
